// File: rtl/vector_alu_sequencer_if.sv
// vector_alu_sequencer_if: handshake, register-file and ALU signals shared by execute and the vector sequencer
interface vector_alu_sequencer_if #(
    parameter int VLEN = 4,
    parameter int DW   = 16
);
    localparam int EW = (VLEN > 1) ? $clog2(VLEN) : 1;
    logic          start_valid;
    logic          start_ready;
    logic [3:0]    op;
    logic [3:0]    va;
    logic [3:0]    vb;
    logic [3:0]    vt;
    logic [3:0]    vrf_ra_idx;
    logic [3:0]    vrf_rb_idx;
    logic [EW-1:0] vrf_elem;
    logic [DW-1:0] vrf_ra_val;
    logic [DW-1:0] vrf_rb_val;
    logic          vrf_we;
    logic [3:0]    vrf_waddr;
    logic [DW-1:0] vrf_wdata;
    logic          alu_sel;
    logic [DW-1:0] alu_a;
    logic [DW-1:0] alu_b;
    logic [1:0]    alu_op;
    logic [DW-1:0] alu_result;
    logic          scalar_req;
    logic          scalar_gnt;
    logic          rf_we;
    logic [3:0]    rf_waddr;
    logic [DW-1:0] rf_wdata;
    logic          busy;
    logic          done;
    modport master (
        output start_valid, op, va, vb, vt, vrf_ra_val, vrf_rb_val, alu_result, scalar_req,
        input  start_ready, vrf_ra_idx, vrf_rb_idx, vrf_elem, vrf_we, vrf_waddr, vrf_wdata,
               alu_sel, alu_a, alu_b, alu_op, scalar_gnt, rf_we, rf_waddr, rf_wdata, busy, done
    );
    modport slave (
        input  start_valid, op, va, vb, vt, vrf_ra_val, vrf_rb_val, alu_result, scalar_req,
        output start_ready, vrf_ra_idx, vrf_rb_idx, vrf_elem, vrf_we, vrf_waddr, vrf_wdata,
               alu_sel, alu_a, alu_b, alu_op, scalar_gnt, rf_we, rf_waddr, rf_wdata, busy, done
    );
endinterface

// File: rtl/vector_alu_sequencer.sv
// vector_alu_sequencer: steps vector ops element by element through the shared ALU, alternating fairly with scalar requests
module vector_alu_sequencer #(
    parameter int VLEN = 4,
    parameter int DW   = 16
) (
    input logic                    clk,
    input logic                    rst_n,
    vector_alu_sequencer_if.slave  bus
);
    localparam int         EW      = (VLEN > 1) ? $clog2(VLEN) : 1;
    localparam logic [3:0] OP_VDOT = 4'b1110;

    typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

    state_t        state_q, state_d;
    logic [3:0]    op_q, op_d, va_q, va_d, vb_q, vb_d, vt_q, vt_d;
    logic [EW-1:0] elem_q, elem_d;
    logic [DW-1:0] acc_q, acc_d;
    logic          last_vec_q, last_vec_d;
    logic          vec_cyc, is_vdot, op_legal;

    assign is_vdot  = op_q == OP_VDOT;
    assign op_legal = bus.op inside {4'b1000, 4'b1001, 4'b1010, 4'b1011, OP_VDOT};
    // the scalar side only wins a RUN cycle if the vector side had the previous one
    assign vec_cyc  = (state_q == RUN) && !(bus.scalar_req && last_vec_q);

    // State and operand registers; reset discards any op in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            op_q       <= '0;
            va_q       <= '0;
            vb_q       <= '0;
            vt_q       <= '0;
            elem_q     <= '0;
            acc_q      <= '0;
            last_vec_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            va_q       <= va_d;
            vb_q       <= vb_d;
            vt_q       <= vt_d;
            elem_q     <= elem_d;
            acc_q      <= acc_d;
            last_vec_q <= last_vec_d;
        end
    end

    // Next state: accept in IDLE, advance one element per vector cycle, single FINISH cycle
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        va_d       = va_q;
        vb_d       = vb_q;
        vt_d       = vt_q;
        elem_d     = elem_q;
        acc_d      = acc_q;
        last_vec_d = last_vec_q;
        case (state_q)
            IDLE: if (bus.start_valid) begin
                op_d       = bus.op;
                va_d       = bus.va;
                vb_d       = bus.vb;
                vt_d       = bus.vt;
                elem_d     = '0;
                acc_d      = '0;
                last_vec_d = 1'b0;
                state_d    = op_legal ? RUN : FINISH;
            end
            RUN: if (vec_cyc) begin
                acc_d      = is_vdot ? acc_q + bus.alu_result : acc_q;
                elem_d     = elem_q + 1'b1;
                last_vec_d = 1'b1;
                state_d    = (elem_q == EW'(VLEN - 1)) ? FINISH : RUN;
            end else begin
                last_vec_d = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.start_ready = state_q == IDLE;
    assign bus.busy        = state_q != IDLE;
    assign bus.done        = state_q == FINISH;
    assign bus.alu_sel     = vec_cyc;
    assign bus.scalar_gnt  = bus.scalar_req && !vec_cyc;
    assign bus.vrf_ra_idx  = va_q;
    assign bus.vrf_rb_idx  = vb_q;
    assign bus.vrf_elem    = elem_q;
    assign bus.alu_a       = vec_cyc ? bus.vrf_ra_val : '0;
    assign bus.alu_b       = vec_cyc ? bus.vrf_rb_val : '0;
    // opcode low bits already encode the ALU function, and vdot's low bits select mul
    assign bus.alu_op      = vec_cyc ? op_q[1:0] : 2'b00;
    assign bus.vrf_we      = vec_cyc && !is_vdot;
    assign bus.vrf_waddr   = bus.vrf_we ? vt_q : '0;
    assign bus.vrf_wdata   = bus.vrf_we ? bus.alu_result : '0;
    assign bus.rf_we       = (state_q == FINISH) && is_vdot;
    assign bus.rf_waddr    = bus.rf_we ? vt_q : '0;
    assign bus.rf_wdata    = bus.rf_we ? acc_q : '0;
endmodule

// File: tb/tb_vector_alu_sequencer.sv
// tb_vector_alu_sequencer: table, random and hand-written checks against a per-op reference model
module tb_vector_alu_sequencer;
    localparam int VLEN = 4;
    localparam int DW   = 16;

    typedef struct packed {
        logic [3:0]        op;
        logic [0:3][15:0]  a;
        logic [0:3][15:0]  b;
        logic [3:0]        vt;
        int                mode;
        logic [0:3][15:0]  w;
        logic [15:0]       rf;
        int                wcnt;
        int                done_cyc;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    vector_alu_sequencer_if #(.VLEN(VLEN), .DW(DW)) bus ();
    vector_alu_sequencer #(.VLEN(VLEN), .DW(DW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    logic [0:3][15:0] cur_a, cur_b;
    int checks = 0;
    int errors = 0;

    function automatic logic [15:0] alu_fn(input logic [1:0] f, input logic [15:0] a, input logic [15:0] b);
        if (f == 2'd0) return a + b;
        if (f == 2'd1) return a - b;
        if (f == 2'd2) return a * b;
        return (b == 16'd0) ? 16'hFFFF : a / b;
    endfunction

    function automatic logic [15:0] op_fn(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
        logic [31:0] p;
        p = {16'd0, a} * {16'd0, b};
        case (op)
            4'b1000: return a + b;
            4'b1001: return a - b;
            4'b1011: return (b == 16'd0) ? 16'hFFFF : a / b;
            default: return p[15:0];
        endcase
    endfunction

    assign bus.alu_result = alu_fn(bus.alu_op, bus.alu_a, bus.alu_b);
    assign bus.vrf_ra_val = (bus.vrf_ra_idx == 4'd1) ? cur_a[bus.vrf_elem] : 16'h0;
    assign bus.vrf_rb_val = (bus.vrf_rb_idx == 4'd2) ? cur_b[bus.vrf_elem] : 16'h0;

    function automatic logic [48:0] pk(input logic rdy, input logic bsy, input logic dn, input logic gnt,
                                       input logic sel, input logic we, input logic [3:0] wa, input logic [1:0] el,
                                       input logic [15:0] wd, input logic rwe, input logic [3:0] ra, input logic [15:0] rd);
        return {rdy, bsy, dn, gnt, sel, we, we ? {wa, el, wd} : 22'h0, rwe, rwe ? {ra, rd} : 20'h0};
    endfunction

    function automatic logic [48:0] obs();
        return pk(bus.start_ready, bus.busy, bus.done, bus.scalar_gnt, bus.alu_sel, bus.vrf_we, bus.vrf_waddr,
                  bus.vrf_elem, bus.vrf_wdata, bus.rf_we, bus.rf_waddr, bus.rf_wdata);
    endfunction

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    // mode: 0 no scalar requests, 1 scalar_req held high, 2 random scalar_req
    task automatic exec(input logic [3:0] op, input logic [0:3][15:0] a, input logic [0:3][15:0] b,
                        input logic [3:0] vt, input int mode, output logic [0:3][15:0] got_w,
                        output int got_wcnt, output logic [15:0] got_rf, output int got_done);
        int phase, el;
        logic prev_vec, req, vec, vdot;
        logic [15:0] acc, r;
        logic [48:0] exp;
        cur_a = a;
        cur_b = b;
        vdot = op == 4'b1110;
        got_w = '0;
        got_wcnt = 0;
        got_rf = 16'h0;
        got_done = -1;
        @(posedge clk); #1;
        bus.start_valid = 1'b1;
        bus.op = op;
        bus.va = 4'd1;
        bus.vb = 4'd2;
        bus.vt = vt;
        bus.scalar_req = (mode == 1);
        @(negedge clk);
        chk("accept_ready", bus.start_ready, 1);
        chk("idle_gnt", bus.scalar_gnt, (mode == 1) ? 1 : 0);
        @(posedge clk); #1;
        bus.start_valid = 1'b0;
        phase = (op inside {4'b1000, 4'b1001, 4'b1010, 4'b1011, 4'b1110}) ? 1 : 2;
        el = 0;
        prev_vec = 1'b0;
        acc = 16'h0;
        vec = 1'b0;
        r = 16'h0;
        for (int cyc = 1; cyc < 40 && phase != 0; cyc++) begin
            req = (mode == 1) ? 1'b1 : (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
            bus.scalar_req = req;
            if (phase == 1) begin
                vec = !(req && prev_vec);
                r = op_fn(op, a[el], b[el]);
                exp = pk(0, 1, 0, !vec, vec, vec && !vdot, vt, el[1:0], r, 0, 4'd0, 16'd0);
            end else if (phase == 2) begin
                exp = pk(0, 1, 1, req, 0, 0, 4'd0, 2'd0, 16'd0, vdot, vt, acc);
            end else begin
                exp = pk(1, 0, 0, req, 0, 0, 4'd0, 2'd0, 16'd0, 0, 4'd0, 16'd0);
            end
            @(negedge clk);
            if (bus.vrf_we) begin
                got_w[bus.vrf_elem] = bus.vrf_wdata;
                got_wcnt++;
            end
            if (bus.rf_we) got_rf = bus.rf_wdata;
            if (bus.done && got_done < 0) got_done = cyc;
            chk($sformatf("cycle op=%h cyc=%0d", op, cyc), obs(), exp);
            if (phase == 1) begin
                if (vec) begin
                    if (vdot) acc = acc + r;
                    el++;
                    prev_vec = 1'b1;
                    if (el == VLEN) phase = 2;
                end else begin
                    prev_vec = 1'b0;
                end
            end else if (phase == 2) begin
                phase = 3;
            end else begin
                phase = 0;
            end
            if (phase != 0) begin
                @(posedge clk); #1;
            end
        end
        bus.scalar_req = 1'b0;
    endtask

    vec_t tbl [8];
    logic [0:3][15:0] gw, ra, rb;
    int gcnt, gdone, n;
    logic [15:0] grf;
    logic [3:0] rops [6];

    initial begin
        tbl[0] = '{op:4'h8, a:{16'd1, 16'd2, 16'd3, 16'd4}, b:{16'd10, 16'd20, 16'd30, 16'd40}, vt:4'd3, mode:0,
                   w:{16'd11, 16'd22, 16'd33, 16'd44}, rf:16'd0, wcnt:4, done_cyc:5};
        tbl[1] = '{op:4'hE, a:{16'd1, 16'd2, 16'd3, 16'd4}, b:{16'd5, 16'd6, 16'd7, 16'd8}, vt:4'd2, mode:0,
                   w:'0, rf:16'd70, wcnt:0, done_cyc:5};
        tbl[2] = '{op:4'h9, a:{16'd0, 16'd5, 16'd100, 16'd7}, b:{16'd1, 16'd3, 16'd50, 16'd7}, vt:4'd4, mode:0,
                   w:{16'hFFFF, 16'd2, 16'd50, 16'd0}, rf:16'd0, wcnt:4, done_cyc:5};
        tbl[3] = '{op:4'hE, a:{16'h8000, 16'h4000, 16'd0, 16'd0}, b:{16'd1, 16'd2, 16'd0, 16'd0}, vt:4'd5, mode:0,
                   w:'0, rf:16'h0000, wcnt:0, done_cyc:5};
        tbl[4] = '{op:4'h8, a:{16'd1, 16'd2, 16'd3, 16'd4}, b:{16'd1, 16'd1, 16'd1, 16'd1}, vt:4'd6, mode:1,
                   w:{16'd2, 16'd3, 16'd4, 16'd5}, rf:16'd0, wcnt:4, done_cyc:8};
        tbl[5] = '{op:4'hA, a:{16'd3, 16'h0100, 16'hFFFF, 16'd7}, b:{16'd5, 16'h0100, 16'd2, 16'd0}, vt:4'd7, mode:0,
                   w:{16'd15, 16'h0000, 16'hFFFE, 16'd0}, rf:16'd0, wcnt:4, done_cyc:5};
        tbl[6] = '{op:4'hB, a:{16'd100, 16'd7, 16'd0, 16'd9}, b:{16'd7, 16'd2, 16'd5, 16'd0}, vt:4'd8, mode:0,
                   w:{16'd14, 16'd3, 16'd0, 16'hFFFF}, rf:16'd0, wcnt:4, done_cyc:5};
        tbl[7] = '{op:4'h0, a:{16'd1, 16'd2, 16'd3, 16'd4}, b:{16'd1, 16'd2, 16'd3, 16'd4}, vt:4'd9, mode:0,
                   w:'0, rf:16'd0, wcnt:0, done_cyc:1};
        rops = '{4'h8, 4'h9, 4'hA, 4'hB, 4'hE, 4'h3};
        bus.start_valid = 1'b0;
        bus.op = 4'h0;
        bus.va = 4'h0;
        bus.vb = 4'h0;
        bus.vt = 4'h0;
        bus.scalar_req = 1'b0;
        cur_a = '0;
        cur_b = '0;
        #3;
        chk("reset_outputs", obs(), pk(1, 0, 0, 0, 0, 0, 4'd0, 2'd0, 16'd0, 0, 4'd0, 16'd0));
        chk("reset_data", {bus.vrf_ra_idx, bus.vrf_rb_idx, bus.vrf_elem, bus.alu_a, bus.alu_b, bus.alu_op}, 0);
        bus.scalar_req = 1'b1;
        #1;
        chk("reset_gnt", bus.scalar_gnt, 1);
        bus.scalar_req = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            exec(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].vt, tbl[i].mode, gw, gcnt, grf, gdone);
            if (tbl[i].wcnt > 0) chk($sformatf("tbl%0d_wdata", i), gw, tbl[i].w);
            chk($sformatf("tbl%0d_wcnt", i), gcnt, tbl[i].wcnt);
            chk($sformatf("tbl%0d_rf", i), grf, tbl[i].rf);
            chk($sformatf("tbl%0d_done", i), gdone, tbl[i].done_cyc);
        end

        for (int i = 0; i < 30; i++) begin
            for (int e = 0; e < VLEN; e++) begin
                ra[e] = 16'($urandom);
                rb[e] = ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom);
            end
            exec(rops[$urandom_range(0, 5)], ra, rb, 4'($urandom_range(3, 15)), 2, gw, gcnt, grf, gdone);
        end

        // illegal op with a second start offered while FINISH is showing
        cur_a = {16'd5, 16'd6, 16'd7, 16'd8};
        cur_b = {16'd1, 16'd1, 16'd1, 16'd1};
        @(posedge clk); #1;
        bus.start_valid = 1'b1;
        bus.op = 4'h0;
        bus.va = 4'd1;
        bus.vb = 4'd2;
        bus.vt = 4'd9;
        @(negedge clk);
        chk("ill_c0_ready", bus.start_ready, 1);
        @(posedge clk); #1;
        bus.op = 4'h8;
        @(negedge clk);
        chk("ill_c1", {bus.done, bus.start_ready, bus.busy, bus.vrf_we, bus.rf_we}, 5'b10100);
        @(posedge clk); #1;
        @(negedge clk);
        chk("ill_c2", {bus.done, bus.start_ready, bus.busy}, 3'b010);
        @(posedge clk); #1;
        bus.start_valid = 1'b0;
        @(negedge clk);
        chk("ill_c3", {bus.busy, bus.vrf_we, bus.vrf_waddr, bus.vrf_wdata}, {1'b1, 1'b1, 4'd9, 16'd6});
        n = 0;
        while (!bus.start_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("ill_drain", bus.start_ready, 1);

        // asynchronous reset in the middle of RUN
        @(posedge clk); #1;
        bus.start_valid = 1'b1;
        bus.op = 4'h8;
        bus.vt = 4'd10;
        @(posedge clk); #1;
        bus.start_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("rst_elem", bus.vrf_elem, 2);
        bus.scalar_req = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_async", obs(), pk(1, 0, 0, 1, 0, 0, 4'd0, 2'd0, 16'd0, 0, 4'd0, 16'd0));
        chk("rst_async_data", {bus.vrf_elem, bus.alu_a, bus.alu_b, bus.alu_op}, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        bus.scalar_req = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk($sformatf("rst_after%0d", i), obs(), pk(1, 0, 0, 0, 0, 0, 4'd0, 2'd0, 16'd0, 0, 4'd0, 16'd0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
